// File: rtl/dtw_pkg.sv
// Shared FSM encoding and default sizing for the DTW pair reader.
package dtw_pkg;

  localparam int unsigned DTW_N_DEF = 32;
  localparam int unsigned DTW_A_DEF = 8;

  // Largest representable cost at the default sample width.
  localparam logic [DTW_N_DEF-1:0] DTW_SAT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } dtw_state_e;

endpackage

// File: rtl/dtw_cost_skid.sv
// Two-entry output buffer for cost pairs; head entry drives the output directly.
module dtw_cost_skid #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         ready_i,
  output logic         valid_o,
  output logic [W-1:0] dout_o,
  output logic [1:0]   count_o
);

  logic [1:0]   cnt_q, cnt_d;
  logic [W-1:0] e0_q, e0_d, e1_q, e1_d;
  logic         vld_q, vld_d;
  logic         pop_c;

  always_comb begin
    cnt_d = cnt_q;
    e0_d  = e0_q;
    e1_d  = e1_q;
    pop_c = vld_q && ready_i;
    unique case ({push_i, pop_c})
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - 2'd1;
      end
      2'b10: begin
        if (cnt_q == 2'd0) e0_d = din_i;
        else               e1_d = din_i;
        cnt_d = cnt_q + 2'd1;
      end
      // Simultaneous push/pop: new entry lands behind whatever remains.
      2'b11: begin
        if (cnt_q == 2'd1) begin
          e0_d = din_i;
        end else begin
          e0_d = e1_q;
          e1_d = din_i;
        end
      end
      default: ;
    endcase
    vld_d = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
      e0_q  <= '0;
      e1_q  <= '0;
      vld_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      e0_q  <= e0_d;
      e1_q  <= e1_d;
      vld_q <= vld_d;
    end
  end

  assign valid_o = vld_q;
  assign dout_o  = e0_q;
  assign count_o = cnt_q;

endmodule

// File: rtl/dtw_pair_reader.sv
// Sweeps all (test i, template j) pairs, reads both memories and emits per-pair local cost.
// Define DTW_SQUARED_COST_EN for squared-difference cost with one extra pipeline stage.
module dtw_pair_reader
  import dtw_pkg::*;
#(
  parameter int unsigned N = DTW_N_DEF,
  parameter int unsigned A = DTW_A_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [A-1:0] temp_last,
  input  logic [A-1:0] test_last,
  output logic [A-1:0] temp_mem_addr,
  output logic [A-1:0] test_mem_addr,
  input  logic [N-1:0] temp_memory_out,
  input  logic [N-1:0] test_memory_out,
  output logic [N-1:0] cost_data,
  output logic [A-1:0] cost_i,
  output logic [A-1:0] cost_j,
  output logic         cost_valid,
  input  logic         cost_ready,
  output logic         cost_last,
  output logic         busy,
  output logic         done
);

  localparam int unsigned W = N + 2*A + 1;
  localparam logic [N-1:0] SAT_MAX = '1;

  dtw_state_e   state_q, state_d;
  logic [A-1:0] i_q, i_d, j_q, j_d, il_q, il_d, jl_q, jl_d;
  logic         s1_v_q, s1_v_d, s1_last_q, s1_last_d;
  logic [A-1:0] s1_i_q, s1_i_d, s1_j_q, s1_j_d;
  logic         busy_q, busy_d, done_q, done_d;
  logic         issue_c, last_pair_c, pop_c, push_c;
  logic [2:0]   occ_c;
  logic [1:0]   buf_cnt;
  logic [W-1:0] sk_din, sk_dout;
  logic signed [N:0] diff_c;
  logic [N-1:0] cost_c;

  // Difference at N+1 bits cannot overflow for any pair of N-bit signed samples.
  assign diff_c = {test_memory_out[N-1], test_memory_out}
                - {temp_memory_out[N-1], temp_memory_out};

`ifdef DTW_SQUARED_COST_EN
  logic              s2_v_q, s2_last_q;
  logic [A-1:0]      s2_i_q, s2_j_q;
  logic signed [N:0] s2_diff_q;
  logic signed [2*N+1:0] dx_c, sq_c;

  always_comb begin
    dx_c   = {{(N+1){s2_diff_q[N]}}, s2_diff_q};
    sq_c   = dx_c * dx_c;
    cost_c = (sq_c[2*N+1:N] != '0) ? SAT_MAX : sq_c[N-1:0];
    push_c = s2_v_q;
    sk_din = {s2_last_q, s2_i_q, s2_j_q, cost_c};
    pop_c  = cost_valid && cost_ready;
    occ_c  = 3'(buf_cnt) + 3'(s1_v_q) + 3'(s2_v_q) - 3'(pop_c);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s2_v_q    <= 1'b0;
      s2_last_q <= 1'b0;
      s2_i_q    <= '0;
      s2_j_q    <= '0;
      s2_diff_q <= '0;
    end else begin
      s2_v_q    <= s1_v_q;
      s2_last_q <= s1_last_q;
      s2_i_q    <= s1_i_q;
      s2_j_q    <= s1_j_q;
      s2_diff_q <= diff_c;
    end
  end
`else
  logic [N:0] mag_c;

  always_comb begin
    mag_c  = diff_c[N] ? (N+1)'(-diff_c) : (N+1)'(diff_c);
    cost_c = mag_c[N] ? SAT_MAX : mag_c[N-1:0];
    push_c = s1_v_q;
    sk_din = {s1_last_q, s1_i_q, s1_j_q, cost_c};
    pop_c  = cost_valid && cost_ready;
    occ_c  = 3'(buf_cnt) + 3'(s1_v_q) - 3'(pop_c);
  end
`endif

  // Next state, index walk and read issue; a read goes out only if its result is guaranteed a slot.
  always_comb begin
    state_d     = state_q;
    i_d         = i_q;
    j_d         = j_q;
    il_d        = il_q;
    jl_d        = jl_q;
    done_d      = 1'b0;
    last_pair_c = (i_q == il_q) && (j_q == jl_q);
    issue_c     = (state_q == ST_RUN) && (occ_c < 3'd2);
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          i_d     = '0;
          j_d     = '0;
          il_d    = test_last;
          jl_d    = temp_last;
        end
      end
      ST_RUN: begin
        if (issue_c) begin
          if (last_pair_c) begin
            state_d = ST_DRAIN;
          end else if (j_q == jl_q) begin
            j_d = '0;
            i_d = i_q + A'(1);
          end else begin
            j_d = j_q + A'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (pop_c && cost_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d    = (state_d != ST_IDLE);
    s1_v_d    = issue_c;
    s1_i_d    = i_q;
    s1_j_d    = j_q;
    s1_last_d = last_pair_c;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      il_q      <= '0;
      jl_q      <= '0;
      s1_v_q    <= 1'b0;
      s1_i_q    <= '0;
      s1_j_q    <= '0;
      s1_last_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      il_q      <= il_d;
      jl_q      <= jl_d;
      s1_v_q    <= s1_v_d;
      s1_i_q    <= s1_i_d;
      s1_j_q    <= s1_j_d;
      s1_last_q <= s1_last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  dtw_cost_skid #(.W(W)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .din_i   (sk_din),
    .ready_i (cost_ready),
    .valid_o (cost_valid),
    .dout_o  (sk_dout),
    .count_o (buf_cnt)
  );

  assign cost_last     = sk_dout[W-1];
  assign cost_i        = sk_dout[W-2 -: A];
  assign cost_j        = sk_dout[N+A-1 -: A];
  assign cost_data     = sk_dout[N-1:0];
  assign test_mem_addr = i_q;
  assign temp_mem_addr = j_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_dtw_pair_reader.sv
// Directed bench for dtw_pair_reader: synchronous 1-cycle memories, ordered pair checks, handshake and reset cases.
module tb_dtw_pair_reader;

  localparam int unsigned N = 32;
  localparam int unsigned A = 8;
`ifdef DTW_SQUARED_COST_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic         clk = 1'b0;
  logic         rst, start, cost_ready;
  logic [A-1:0] temp_last, test_last, temp_mem_addr, test_mem_addr, cost_i, cost_j;
  logic [N-1:0] temp_memory_out, test_memory_out, cost_data;
  logic         cost_valid, cost_last, busy, done;

  logic [N-1:0] temp_mem [256];
  logic [N-1:0] test_mem [256];

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] exp_cost [64];
  logic [A-1:0] exp_i [64];
  logic [A-1:0] exp_j [64];
  logic         exp_last [64];
  int           exp_n = 0;
  int           ptr = 0;
  int           hand [6];

  dtw_pair_reader #(.N(N), .A(A)) dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .temp_last       (temp_last),
    .test_last       (test_last),
    .temp_mem_addr   (temp_mem_addr),
    .test_mem_addr   (test_mem_addr),
    .temp_memory_out (temp_memory_out),
    .test_memory_out (test_memory_out),
    .cost_data       (cost_data),
    .cost_i          (cost_i),
    .cost_j          (cost_j),
    .cost_valid      (cost_valid),
    .cost_ready      (cost_ready),
    .cost_last       (cost_last),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    temp_memory_out <= temp_mem[temp_mem_addr];
    test_memory_out <= test_mem[test_mem_addr];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] ref_cost(input logic [N-1:0] a, input logic [N-1:0] b);
    longint d, m;
    d = longint'($signed(a)) - longint'($signed(b));
    m = (d < 0) ? -d : d;
`ifdef DTW_SQUARED_COST_EN
    if (m >= 65536) return '1;
    m = m * m;
`endif
    if (m > 64'hFFFF_FFFF) return '1;
    return m[31:0];
  endfunction

  task automatic build_exp(input int sl, input int tl);
    exp_n = 0;
    for (int i = 0; i <= sl; i++) begin
      for (int j = 0; j <= tl; j++) begin
        exp_cost[exp_n] = ref_cost(test_mem[i], temp_mem[j]);
        exp_i[exp_n]    = A'(i);
        exp_j[exp_n]    = A'(j);
        exp_last[exp_n] = (i == sl) && (j == tl);
        exp_n++;
      end
    end
    ptr = 0;
  endtask

  // mode 0: ready held high; mode 1: ready 1,0,0,1 repeating.
  task automatic run_sweep(input int sl, input int tl, input int mode,
                           input int restart_at, input int abort_after);
    int first_c, prev_ptr;
    bit done_seen;
    logic seen_bad;
    first_c = -1; prev_ptr = 0; done_seen = 1'b0;
    @(posedge clk); #1;
    test_last = A'(sl); temp_last = A'(tl); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int c = 0; c < 400 && !done_seen; c++) begin
      if (done) begin
        done_seen = 1'b1;
        check("done_all_pairs", ptr, exp_n);
        check("done_after_last", prev_ptr, exp_n - 1);
        check("busy_at_done", busy, 0);
        check("addr_hold", {test_mem_addr, temp_mem_addr}, {A'(sl), A'(tl)});
        if (mode == 0 && restart_at < 0) check("first_valid_lat", first_c, LAT);
      end else begin
        if (abort_after >= 0 && ptr == abort_after) begin
          rst = 1'b0; cost_ready = 1'b0;
          @(posedge clk); #1;
          check("rst_valid", cost_valid, 0);
          check("rst_busy", busy, 0);
          check("rst_done", done, 0);
          check("rst_addr", {test_mem_addr, temp_mem_addr}, 0);
          check("rst_cost", {cost_data, cost_i, cost_j, cost_last}, 0);
          rst = 1'b1; cost_ready = 1'b1;
          seen_bad = 1'b0;
          repeat (6) begin
            @(negedge clk);
            seen_bad = seen_bad | cost_valid | done;
          end
          check("rst_quiet", seen_bad, 0);
          return;
        end
        if (c == restart_at) begin
          start = 1'b1; test_last = 1; temp_last = 0;
        end
        if (c == restart_at + 1) start = 1'b0;
        cost_ready = (mode == 0) || (c % 4 == 0) || (c % 4 == 3);
        prev_ptr = ptr;
        @(negedge clk);
        if (cost_valid) begin
          if (first_c < 0) first_c = c;
          if (ptr < exp_n) begin
            check($sformatf("cost[%0d]", ptr), cost_data, exp_cost[ptr]);
            check($sformatf("idx[%0d]", ptr), {cost_i, cost_j}, {exp_i[ptr], exp_j[ptr]});
            check($sformatf("last[%0d]", ptr), cost_last, exp_last[ptr]);
            if (cost_ready) ptr++;
          end else begin
            check("extra_pair", cost_valid, 0);
          end
        end
        @(posedge clk); #1;
      end
    end
    if (!done_seen) begin
      check("sweep_timeout", done_seen, 1);
    end else begin
      @(posedge clk); #1;
      check("done_pulse", done, 0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; cost_ready = 1'b0; temp_last = '0; test_last = '0;
    for (int k = 0; k < 256; k++) begin
      temp_mem[k] = '0;
      test_mem[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", cost_valid, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_addr", {test_mem_addr, temp_mem_addr}, 0);
    check("reset_cost", {cost_data, cost_i, cost_j, cost_last}, 0);
    rst = 1'b1;

    // 3x2 reference sweep with hand-computed costs
    test_mem[0] = 5; test_mem[1] = -3; test_mem[2] = 7;
    temp_mem[0] = 2; temp_mem[1] = 10;
`ifdef DTW_SQUARED_COST_EN
    hand = '{9, 25, 25, 169, 25, 9};
`else
    hand = '{3, 5, 5, 13, 5, 3};
`endif
    build_exp(2, 1);
    for (int k = 0; k < 6; k++) exp_cost[k] = N'(hand[k]);
    run_sweep(2, 1, 0, -1, -1);

    // 1x1 extreme operands: saturated cost
    test_mem[0] = 32'h7FFF_FFFF; temp_mem[0] = 32'h8000_0000;
    build_exp(0, 0);
    exp_cost[0] = 32'hFFFF_FFFF;
    run_sweep(0, 0, 0, -1, -1);

    // 1x1 small operands
    test_mem[0] = 4; temp_mem[0] = 1;
    build_exp(0, 0);
`ifdef DTW_SQUARED_COST_EN
    exp_cost[0] = 9;
`else
    exp_cost[0] = 3;
`endif
    run_sweep(0, 0, 0, -1, -1);

    // 3x3 under periodic backpressure
    test_mem[0] = 100; test_mem[1] = -50; test_mem[2] = 32'h7FFF_FFFF;
    temp_mem[0] = -100; temp_mem[1] = 25; temp_mem[2] = 32'h8000_0000;
    build_exp(2, 2);
    run_sweep(2, 2, 1, -1, -1);

    // start re-pulsed mid-sweep with other lengths is ignored
    build_exp(2, 2);
    run_sweep(2, 2, 0, 3, -1);

    // 4x4 aborted by reset after 4 transfers, then a clean full run
    for (int k = 0; k < 4; k++) begin
      test_mem[k] = 32'(k * 7 - 9);
      temp_mem[k] = 32'(3 - k * 11);
    end
    build_exp(3, 3);
    run_sweep(3, 3, 0, -1, 4);
    build_exp(3, 3);
    run_sweep(3, 3, 0, -1, -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dtw_pair_reader.md
DTW_PAIR_READER -- requirements
Module: dtw_pair_reader

Interface
REQ-001 Parameter N, default 32: sample width in the template and test memories, in bits.
REQ-002 Parameter A, default 8: memory address width (256-sample depth).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous, active-low reset.
REQ-005 start  in  1  one-cycle request to begin a sweep; sampled only in IDLE.
REQ-006 temp_last  in  A  template length minus 1, latched at start.
REQ-007 test_last  in  A  test length minus 1, latched at start.
REQ-008 temp_mem_addr, test_mem_addr  out  A  read addresses to the template/test memories.
REQ-009 temp_memory_out, test_memory_out  in  N  memory read data, valid one clk after address.
REQ-010 cost_data  out  N  local cost for pair (i,j); cost_i, cost_j  out  A  pair indices.
REQ-011 cost_valid  out  1, cost_ready  in  1: valid/ready output handshake; cost_last  out  1 marks the final pair.
REQ-012 busy  out  1  high from accepted start until done; done  out  1  one-cycle pulse after last transfer.

Function
REQ-013 Sweep order: i (test) outer 0..test_last, j (template) inner 0..temp_last; (test_last+1)*(temp_last+1) pairs, each emitted exactly once.
REQ-014 Samples are signed two's complement; cost = |test[i] - temp[j]| computed at N+1 bits, saturated to 2^N-1.
REQ-015 Memory read latency is exactly 1 clk; the address issued in cycle t pairs with data sampled in t+1.
REQ-016 The output stage is a 2-entry buffer; a read is issued only when (buffered + in-flight) < 2, so no pair is dropped under backpressure.
REQ-017 With cost_ready held high, the first cost_valid appears 2 clk after start is accepted; throughput thereafter is 1 pair/clk.
REQ-018 A transfer occurs when cost_valid && cost_ready; cost_data/i/j/last hold stable while cost_valid && !cost_ready.
REQ-019 FSM: IDLE -(start)-> RUN -(last address issued)-> DRAIN -(last pair transferred)-> IDLE with done=1 for that cycle.
REQ-020 start while busy is ignored; temp_last/test_last changes while busy are ignored.
REQ-021 Lengths of 1 (last=0) are legal; a 1x1 sweep emits one pair with cost_last=1.
REQ-022 Index wrap: j returns to 0 and i increments in the same cycle j passes temp_last; no address beyond temp_last/test_last is issued.
REQ-023 Addresses hold their last value while no read is issued.

Reset
REQ-024 When rst=0 at a clk edge: FSM to IDLE, buffer emptied, in-flight read discarded, all outputs 0 (addresses, cost_*, busy, done).
REQ-025 Reset mid-sweep aborts with no further cost_valid and no done pulse.

Configuration
REQ-026 Macro DTW_SQUARED_COST_EN defined: cost = (test[i]-temp[j])^2 computed at 2N+2 bits, saturated to 2^N-1, adding exactly one pipeline stage (first cost_valid 3 clk after start; buffer accounting counts both in-flight stages).
REQ-027 Macro undefined: absolute-difference cost per REQ-014 and latency per REQ-017.

Structure
REQ-028 Package dtw_pkg holds the FSM state enum, default N/A constants, and the saturation max constant.
REQ-029 The 2-entry output buffer is a sub-module dtw_cost_skid; the FSM, counters and cost arithmetic stay in dtw_pair_reader.

Verification
REQ-030 test_last=2, temp_last=1, ready=1, test={5,-3,7}, temp={2,10}: costs 3,5,5,13,5,3 in order, cost_last on 6th, done one clk later.
REQ-031 last=0/0, test={0x7FFFFFFF}, temp={0x80000000}: single cost 0xFFFFFFFF (saturated), cost_last=1.
REQ-032 3x3 sweep with cost_ready toggling 1,0,0,1 repeating: all 9 pairs in order, none dropped or duplicated, data stable while stalled.
REQ-033 start pulsed again mid-sweep with different lengths: ignored, original sweep completes unchanged.
REQ-034 rst=0 asserted after 4 transfers of a 4x4 sweep: all outputs 0 next clk, no done; new start then runs a full sweep correctly.
REQ-035 With DTW_SQUARED_COST_EN, test={4}, temp={1}: cost 9, first cost_valid 3 clk after start.
